// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl
// Turns the byte stream from a UART receiver into framed command packets:
//   SYNC_BYTE, length, payload[length], checksum
// The checksum is valid when length + payload + checksum sums to 0 mod 256.
// A validated payload is held in a local register file until the consumer
// acknowledges it. Length, checksum, inter-byte timeout and overrun faults
// each produce a single-cycle error pulse and drop the offending traffic.
module uart_rx_packet_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 100_000,
  localparam int        AW             = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1,
  localparam int        LW             = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_data_valid,
  input  logic [AW-1:0] pkt_rd_addr,
  output logic [7:0]    pkt_rd_data,
  output logic          pkt_valid,
  output logic [LW-1:0] pkt_len,
  input  logic          pkt_ack,
  output logic          busy,
  output logic          err_checksum,
  output logic          err_length,
  output logic          err_timeout,
  output logic          err_overrun
);

  // The timeout counter only has to represent 0 .. TIMEOUT_CYCLES-1: the
  // cycle on which it would reach TIMEOUT_CYCLES is the expiry cycle itself.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_WAIT_SYNC    = 3'd0,
    S_GET_LEN      = 3'd1,
    S_GET_PAYLOAD  = 3'd2,
    S_GET_CHECKSUM = 3'd3,
    S_HOLD         = 3'd4
  } state_t;

  // Running checksum is a plain 8-bit sum that wraps.
  function automatic logic [7:0] add_wrap8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic [LW-1:0] pkt_len_q, pkt_len_d;
  logic          busy_q, busy_d;
  logic          err_checksum_q, err_checksum_d;
  logic          err_length_q, err_length_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_overrun_q, err_overrun_d;
  logic          buf_we;

  // Payload storage; deliberately never cleared, pkt_valid/pkt_len gate its use.
  logic [7:0]    buf_q [MAX_PAYLOAD];

  // Decoded conditions shared by the next-state and output logic.
  logic          tmo_expire;
  logic          len_too_big;
  logic          len_is_zero;
  logic          last_payload;
  logic          csum_ok;
  logic          is_sync;

  assign tmo_expire   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign len_too_big  = (rx_data > 8'(MAX_PAYLOAD));
  assign len_is_zero  = (rx_data == 8'd0);
  assign last_payload = ((8'(idx_q) + 8'd1) == len_q);
  assign csum_ok      = (add_wrap8(sum_q, rx_data) == 8'd0);
  assign is_sync      = (rx_data == SYNC_BYTE);

  // State register plus all registered datapath and output state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_WAIT_SYNC;
      len_q          <= '0;
      sum_q          <= '0;
      idx_q          <= '0;
      tmo_q          <= '0;
      pkt_valid_q    <= 1'b0;
      pkt_len_q      <= '0;
      busy_q         <= 1'b0;
      err_checksum_q <= 1'b0;
      err_length_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      sum_q          <= sum_d;
      idx_q          <= idx_d;
      tmo_q          <= tmo_d;
      pkt_valid_q    <= pkt_valid_d;
      pkt_len_q      <= pkt_len_d;
      busy_q         <= busy_d;
      err_checksum_q <= err_checksum_d;
      err_length_q   <= err_length_d;
      err_timeout_q  <= err_timeout_d;
      err_overrun_q  <= err_overrun_d;
    end
  end

  // Payload write port; idx_q always stays below MAX_PAYLOAD while writing.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[idx_q] <= rx_data;
    end
  end

  // Next-state logic: an arriving byte always takes priority over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_SYNC: begin
        if (rx_data_valid && is_sync) begin
          state_d = S_GET_LEN;
        end
      end
      S_GET_LEN: begin
        if (rx_data_valid) begin
          if (len_too_big) begin
            state_d = S_WAIT_SYNC;
          end else if (len_is_zero) begin
            state_d = S_GET_CHECKSUM;
          end else begin
            state_d = S_GET_PAYLOAD;
          end
        end else if (tmo_expire) begin
          state_d = S_WAIT_SYNC;
        end
      end
      S_GET_PAYLOAD: begin
        if (rx_data_valid) begin
          if (last_payload) begin
            state_d = S_GET_CHECKSUM;
          end
        end else if (tmo_expire) begin
          state_d = S_WAIT_SYNC;
        end
      end
      S_GET_CHECKSUM: begin
        if (rx_data_valid) begin
          state_d = csum_ok ? S_HOLD : S_WAIT_SYNC;
        end else if (tmo_expire) begin
          state_d = S_WAIT_SYNC;
        end
      end
      S_HOLD: begin
        // A byte coinciding with the ack is an overrun, never a new sync.
        if (pkt_ack) begin
          state_d = S_WAIT_SYNC;
        end
      end
      default: begin
        state_d = S_WAIT_SYNC;
      end
    endcase
  end

  // Output and datapath next values; the timeout counter idles at zero
  // outside the receive states so entry into GET_LEN starts from a clear count.
  always_comb begin
    len_d          = len_q;
    sum_d          = sum_q;
    idx_d          = idx_q;
    tmo_d          = '0;
    pkt_valid_d    = pkt_valid_q;
    pkt_len_d      = pkt_len_q;
    err_checksum_d = 1'b0;
    err_length_d   = 1'b0;
    err_timeout_d  = 1'b0;
    err_overrun_d  = 1'b0;
    buf_we         = 1'b0;
    case (state_q)
      S_GET_LEN: begin
        if (rx_data_valid) begin
          len_d        = rx_data;
          sum_d        = rx_data;
          idx_d        = '0;
          err_length_d = len_too_big;
        end else if (tmo_expire) begin
          err_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GET_PAYLOAD: begin
        if (rx_data_valid) begin
          buf_we = 1'b1;
          sum_d  = add_wrap8(sum_q, rx_data);
          idx_d  = idx_q + AW'(1);
        end else if (tmo_expire) begin
          err_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GET_CHECKSUM: begin
        if (rx_data_valid) begin
          if (csum_ok) begin
            pkt_valid_d = 1'b1;
            pkt_len_d   = LW'(len_q);
          end else begin
            err_checksum_d = 1'b1;
          end
        end else if (tmo_expire) begin
          err_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_HOLD: begin
        err_overrun_d = rx_data_valid;
        if (pkt_ack) begin
          pkt_valid_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  assign busy_d = (state_d != S_WAIT_SYNC);

  // Reads beyond the buffer depth (non power-of-two depths) return zero.
  logic [AW:0] rd_addr_ext;
  assign rd_addr_ext = {1'b0, pkt_rd_addr};
  assign pkt_rd_data = (rd_addr_ext < (AW+1)'(MAX_PAYLOAD)) ? buf_q[pkt_rd_addr] : 8'h00;

  assign pkt_valid    = pkt_valid_q;
  assign pkt_len      = pkt_len_q;
  assign busy         = busy_q;
  assign err_checksum = err_checksum_q;
  assign err_length   = err_length_q;
  assign err_timeout  = err_timeout_q;
  assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Testbench for uart_rx_packet_ctrl: frame-level stimulus with a queue of
// expected events, checked by an independent monitor process.
`timescale 1ns/1ps
module tb_uart_rx_packet_ctrl;
  localparam int         MAXP = 16;
  localparam int         TMO  = 20;
  localparam int         AW   = 4;
  localparam int         LW   = 5;
  localparam logic [7:0] SYNC = 8'hA5;

  localparam int EV_PKT  = 1;
  localparam int EV_CSUM = 2;
  localparam int EV_LEN  = 3;
  localparam int EV_TMO  = 4;
  localparam int EV_OVR  = 5;
  localparam int EV_REL  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_data_valid = 1'b0;
  logic [AW-1:0] pkt_rd_addr = '0;
  logic [7:0]    pkt_rd_data;
  logic          pkt_valid;
  logic [LW-1:0] pkt_len;
  logic          pkt_ack = 1'b0;
  logic          busy;
  logic          err_checksum, err_length, err_timeout, err_overrun;

  uart_rx_packet_ctrl #(
    .SYNC_BYTE(SYNC), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .pkt_rd_addr(pkt_rd_addr), .pkt_rd_data(pkt_rd_data), .pkt_valid(pkt_valid),
    .pkt_len(pkt_len), .pkt_ack(pkt_ack), .busy(busy),
    .err_checksum(err_checksum), .err_length(err_length),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #50 clk = ~clk;

  typedef struct packed {
    logic [2:0]        kind;
    logic              hold;
    logic [7:0]        len;
    logic [31:0]       due;
    logic [MAXP*8-1:0] pl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic rst_seen = 1'b0;
  logic ack_noise = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0d with nothing expected at cycle %0d", name, act, cyc);
  endtask

  // Reference: a frame is good when len + payload + checksum == 0 mod 256.
  function automatic logic [7:0] good_csum(input logic [7:0] len, input logic [MAXP*8-1:0] pl);
    int s;
    s = int'(len);
    for (int i = 0; i < int'(len) && i < MAXP; i++) s += int'(pl[i*8 +: 8]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic expect_ev(input int kind, input logic hold, input logic [7:0] len,
                           input int due, input logic [MAXP*8-1:0] pl);
    exp_t e;
    e.kind = 3'(kind);
    e.hold = hold;
    e.len  = len;
    e.due  = 32'(due);
    e.pl   = pl;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic mon_pv_prev = 1'b0;
  exp_t mon_e;
  int   mon_kind, mon_nerr;

  task automatic check_payload(input exp_t e, input string tag);
    for (int i = 0; i < int'(e.len); i++) begin
      pkt_rd_addr = AW'(i);
      #1;
      chk(tag, int'(pkt_rd_data), int'(e.pl[i*8 +: 8]));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("rst_pkt_valid", int'(pkt_valid), 0);
        chk("rst_pkt_len", int'(pkt_len), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_errors", int'({err_checksum, err_length, err_timeout, err_overrun}), 0);
        mon_pv_prev = 1'b0;
      end else begin
        mon_nerr = int'(err_checksum) + int'(err_length) + int'(err_timeout) + int'(err_overrun);
        mon_kind = err_checksum ? EV_CSUM : err_length ? EV_LEN :
                   err_timeout ? EV_TMO : err_overrun ? EV_OVR : 0;
        if (mon_nerr > 1) fail_now("multiple_errors", mon_nerr);
        if (mon_kind != 0) begin
          if (exp_q.size() == 0) fail_now("unexpected_error_kind", mon_kind);
          else begin
            mon_e = exp_q.pop_front();
            chk("event_kind", mon_kind, int'(mon_e.kind));
            if (mon_kind == EV_TMO && int'(mon_e.kind) == EV_TMO)
              chk("timeout_cycle", cyc, int'(mon_e.due));
            if (mon_kind == EV_OVR && int'(mon_e.kind) == EV_OVR && mon_e.hold) begin
              chk("overrun_pkt_valid", int'(pkt_valid), 1);
              chk("overrun_pkt_len", int'(pkt_len), int'(mon_e.len));
              check_payload(mon_e, "overrun_payload");
            end
          end
        end
        if (mon_pv_prev && pkt_valid !== 1'b1) begin
          if (exp_q.size() == 0) fail_now("unexpected_release", 0);
          else begin
            mon_e = exp_q.pop_front();
            chk("release_kind", EV_REL, int'(mon_e.kind));
            chk("release_busy", int'(busy), 0);
          end
        end
        if (!mon_pv_prev && pkt_valid === 1'b1) begin
          if (exp_q.size() == 0) fail_now("unexpected_packet", int'(pkt_len));
          else begin
            mon_e = exp_q.pop_front();
            chk("packet_kind", EV_PKT, int'(mon_e.kind));
            chk("pkt_len", int'(pkt_len), int'(mon_e.len));
            chk("hold_busy", int'(busy), 1);
            check_payload(mon_e, "payload");
          end
        end
        mon_pv_prev = (pkt_valid === 1'b1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    pkt_ack       = ack_noise & 1'($urandom_range(1));
    last_cyc      = cyc;
    tick();
    rx_data_valid = 1'b0;
    pkt_ack       = 1'b0;
    rx_data       = 8'($urandom);
  endtask

  task automatic garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == SYNC) b = b ^ 8'h01;
      send_byte(b);
      idle($urandom_range(1));
    end
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [MAXP*8-1:0] pl,
                            input logic [7:0] csum, input int maxgap, output int outcome);
    if (int'(len) > MAXP) outcome = EV_LEN;
    else if (csum == good_csum(len, pl)) outcome = EV_PKT;
    else outcome = EV_CSUM;
    expect_ev(outcome, 1'b0, len, 0, pl);
    send_byte(SYNC);
    idle($urandom_range(maxgap));
    send_byte(len);
    if (int'(len) <= MAXP) begin
      for (int i = 0; i < int'(len); i++) begin
        idle($urandom_range(maxgap));
        send_byte(pl[i*8 +: 8]);
      end
      idle($urandom_range(maxgap));
      send_byte(csum);
    end
  endtask

  // mode 0: plain ack; 1: overrun byte then ack; 2: sync byte coincident with ack
  task automatic release_pkt(input int mode, input logic [7:0] len, input logic [MAXP*8-1:0] pl);
    ack_noise = 1'b0;
    idle($urandom_range(2));
    if (mode == 1) begin
      expect_ev(EV_OVR, 1'b1, len, 0, pl);
      send_byte(8'($urandom));
    end
    if (mode == 2) begin
      expect_ev(EV_OVR, 1'b0, len, 0, pl);
      expect_ev(EV_REL, 1'b0, len, 0, pl);
      rx_data       = SYNC;
      rx_data_valid = 1'b1;
    end else begin
      expect_ev(EV_REL, 1'b0, len, 0, pl);
    end
    pkt_ack = 1'b1;
    tick();
    pkt_ack       = 1'b0;
    rx_data_valid = 1'b0;
  endtask

  task automatic rand_payload(output logic [MAXP*8-1:0] pl);
    for (int i = 0; i < MAXP; i++) pl[i*8 +: 8] = 8'($urandom);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [MAXP*8-1:0] pl;
  logic [7:0]        len, cs;
  int                outc, sel, k;

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);

    // Garbage, ack outside HOLD, then the literal test-plan frame (D0 is not
    // a valid checksum for 03,10,20,30 under the sum rule) and the valid one.
    garbage(4);
    pkt_ack = 1'b1; tick(); pkt_ack = 1'b0;
    pl = '0; pl[7:0] = 8'h10; pl[15:8] = 8'h20; pl[23:16] = 8'h30;
    send_frame(8'd3, pl, 8'hD0, 0, outc);
    send_frame(8'd3, pl, 8'h9D, 0, outc);
    release_pkt(1, 8'd3, pl);
    idle(2);

    // Zero-length frame, ack, then a sync on the very next cycle.
    send_frame(8'd0, '0, 8'h00, 0, outc);
    release_pkt(0, 8'd0, '0);
    send_frame(8'd3, pl, 8'h9D, 0, outc);
    release_pkt(2, 8'd3, pl);
    idle(1);

    // Oversize then immediate good frame.
    send_frame(8'h11, '0, 8'h00, 0, outc);
    rand_payload(pl);
    send_frame(8'd16, pl, good_csum(8'd16, pl), 0, outc);
    release_pkt(0, 8'd16, pl);

    // Bad checksum then good frame.
    pl = '0; pl[7:0] = 8'h01; pl[15:8] = 8'h02;
    send_frame(8'd2, pl, 8'h00, 1, outc);
    send_frame(8'd2, pl, good_csum(8'd2, pl), 1, outc);
    release_pkt(0, 8'd2, pl);

    // Timeout after the 55 byte.
    send_byte(SYNC); send_byte(8'd2); send_byte(8'h55);
    expect_ev(EV_TMO, 1'b0, 8'd0, last_cyc + TMO + 1, '0);
    idle(TMO + 4);

    // Byte on the expiry cycle is accepted.
    pl = '0; pl[7:0] = 8'h55; pl[15:8] = 8'h66;
    expect_ev(EV_PKT, 1'b0, 8'd2, 0, pl);
    send_byte(SYNC); send_byte(8'd2); send_byte(8'h55);
    idle(TMO - 1);
    send_byte(8'h66);
    send_byte(good_csum(8'd2, pl));
    release_pkt(0, 8'd2, pl);

    // Reset mid-payload, then reset while holding.
    send_byte(SYNC); send_byte(8'd5); send_byte(8'h11); send_byte(8'h22);
    pulse_reset();
    rand_payload(pl);
    send_frame(8'd4, pl, good_csum(8'd4, pl), 0, outc);
    idle(1);
    pulse_reset();
    rand_payload(pl);
    send_frame(8'd5, pl, good_csum(8'd5, pl), 2, outc);
    release_pkt(1, 8'd5, pl);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(9);
      garbage($urandom_range(2));
      rand_payload(pl);
      ack_noise = 1'($urandom_range(1));
      if (sel <= 4 || sel == 9) begin
        len = 8'($urandom_range(MAXP));
        send_frame(len, pl, good_csum(len, pl), (sel == 9) ? 0 : 3, outc);
        release_pkt($urandom_range(2), len, pl);
      end else if (sel == 5) begin
        len = 8'($urandom_range(MAXP));
        cs  = good_csum(len, pl) ^ 8'($urandom_range(255, 1));
        send_frame(len, pl, cs, 3, outc);
      end else if (sel == 6) begin
        len = 8'($urandom_range(255, MAXP + 1));
        send_frame(len, pl, 8'($urandom), 3, outc);
      end else if (sel == 7) begin
        send_byte(SYNC);
        if ($urandom_range(1) == 1) begin
          len = 8'($urandom_range(MAXP, 1));
          send_byte(len);
          k = $urandom_range(int'(len));
          for (int i = 0; i < k; i++) begin
            idle($urandom_range(3));
            send_byte(pl[i*8 +: 8]);
          end
        end
        expect_ev(EV_TMO, 1'b0, 8'd0, last_cyc + TMO + 1, '0);
        idle(TMO + 3);
      end else begin
        send_byte(SYNC);
        len = 8'($urandom_range(MAXP, 1));
        send_byte(len);
        k = $urandom_range(int'(len) - 1);
        for (int i = 0; i < k; i++) send_byte(pl[i*8 +: 8]);
        pulse_reset();
      end
      ack_noise = 1'b0;
    end

    idle(5);
    chk("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
